opsum_drain_ctrl: RTL and testbench
===================================

Name: opsum_drain_ctrl

Overview:
- Sequencer for the 32-row opsum buffer in pointwise (PW) mode.
- Gates reducer results into the buffer four stores at a time, then drains the full buffer to the GLB one 32-bit word per handshake.
- Generates the word index that selects the buffer output and the matching GLB byte address.
- Sits between the reducer, the opsum buffer and the GLB write port. Owns the valid side of the buffer-to-GLB handshake.

Parameters:
- ROW_NUM, 32, number of buffer rows (each row 4 deep x 16 bit).
- DEPTH, 4, stores per fill round; fixed so that 2 words per row are drained.
- ADDR_W, 32, GLB byte-address width.
- GRP_W, 16, width of the round counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; latches config, begins operation
- cfg_rows  in  6  active rows, 1..32; 0 or >32 treated as 32
- cfg_groups  in  GRP_W  number of fill/drain rounds
- cfg_base_addr  in  ADDR_W  GLB byte address of first drained word
- red_valid  in  1  reducer presents an opsum vector
- red_ready  out  1  controller accepts reducer vector
- store_opsum_f  out  1  buffer store strobe (= red_valid & red_ready)
- valid_op  out  1  buffer word valid toward GLB
- ready_op  in  1  GLB accepts word
- word_idx  out  6  buffer word select, 0..2*rows-1
- glb_addr  out  ADDR_W  byte address of current word
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset values: state IDLE, all counters 0, all outputs 0, glb_addr 0. Reset mid-operation aborts immediately with no drain completion and no done pulse.
- States are IDLE, FILL, DRAIN, DONE.
- IDLE:
  - On start, latch cfg_rows (clamped), cfg_groups and cfg_base_addr, and load addr_ptr = cfg_base_addr.
  - Go to FILL, or to DONE if cfg_groups == 0.
  - start is ignored in every other state.
- FILL:
  - red_ready = 1. store_opsum_f is combinational, same cycle as the red_valid & red_ready handshake.
  - fill_cnt increments per store. The store at fill_cnt == DEPTH-1 clears fill_cnt and moves to DRAIN on the next cycle.
  - red_valid low leaves the state held, with no stores.
- DRAIN:
  - red_ready = 0 and valid_op = 1. valid_op is never deasserted before the handshake completes.
  - word_idx = drain counter and glb_addr = addr_ptr. Both hold stable while ready_op is low.
  - Each valid_op & ready_op handshake increments word_idx and adds 4 to addr_ptr.
  - Handshake at word_idx == 2*rows-1: word_idx goes to 0 and grp_cnt increments.
    - If grp_cnt == cfg_groups-1, go to DONE.
    - Otherwise go to FILL.
  - addr_ptr continues across rounds, so round g word w lands at base + 4*(g*2*rows + w).
- DONE: done = 1 for one cycle, busy = 1, then IDLE. busy drops in the cycle after done.
- Latency:
  - First drained word becomes valid 1 cycle after the 4th store.
  - First store is possible 1 cycle after start.
  - Minimum round length = 4 + 2*rows cycles.
- Width rules:
  - 2*rows is computed at 7 bits, so 64 for rows = 32; word_idx itself never exceeds 63.
  - addr_ptr wraps modulo 2^ADDR_W without an error.
- Boundaries:
  - rows = 1 drains words 0 and 1 only.
  - cfg_groups = 1 gives exactly one round.
  - A red_valid held high across the FILL->DRAIN boundary is not accepted during DRAIN.
  - ready_op held low stalls indefinitely with no timeout.

Decomposition:
- Shared package opsum_pkg:
  - typedef drain_state_e (IDLE, FILL, DRAIN, DONE)
  - constants ROW_NUM = 32, OPSUM_DEPTH = 4, WORDS_PER_ROW = 2, GLB_WORD_BYTES = 4.
- One natural sub-module, opsum_addr_gen: holds addr_ptr and word_idx, with load/advance/wrap inputs.
- The FSM and the fill/group counters stay in the top module.

Test Plan:
- Reset and idle: reset high 3 cycles -> all outputs 0, state IDLE. Pulse start with rows = 2, groups = 1, base = 0x100, red_valid held 1 -> exactly 4 store_opsum_f pulses, then 4 words at idx 0..3 and addr 0x100/0x104/0x108/0x10C, then done one cycle after the last handshake.
- Full array: rows = 32, groups = 2, ready_op always 1 -> 64 words per round; round 2 first address = base + 0x100; total 136 cycles from first store to done.
- Backpressure: rows = 4, ready_op low for 5 cycles on word 3 -> valid_op stays 1, word_idx and glb_addr are stable; the sequence resumes with word 4 and no skips.
- Edge config: rows = 0 -> behaves as 32. groups = 0 -> done 1 cycle after start, no store_opsum_f, no valid_op. rows = 1 -> only idx 0,1 drained.
- Abort and ignore: reset asserted mid-DRAIN at word 5 -> next cycle outputs 0, IDLE, no done. A start pulse during FILL is ignored, with latched cfg and counters unchanged.

Source files
------------

// File: rtl/opsum_pkg.sv
// Shared definitions for the pointwise opsum drain path.
// Contents:
//   drain_state_e  - controller states (IDLE, FILL, DRAIN, DONE)
//   ROW_NUM        - rows in the opsum buffer
//   OPSUM_DEPTH    - reducer stores per fill round (each row is 4 x 16 bit)
//   WORDS_PER_ROW  - 32-bit GLB words produced per buffer row
//   GLB_WORD_BYTES - byte stride between consecutive GLB words
//   clamp_rows()   - maps an out-of-range row count onto the full array
package opsum_pkg;

    localparam int unsigned ROW_NUM        = 32;
    localparam int unsigned OPSUM_DEPTH    = 4;
    localparam int unsigned WORDS_PER_ROW  = 2;
    localparam int unsigned GLB_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } drain_state_e;

    // A row count of 0 or anything above the array size means "use every row".
    function automatic logic [5:0] clamp_rows(input logic [5:0] rows);
        if (rows == 6'd0 || rows > 6'(ROW_NUM)) begin
            return 6'(ROW_NUM);
        end
        return rows;
    endfunction

endpackage

// File: rtl/opsum_drain_ctrl_if.sv
// Handshake bundle between the drain controller, the reducer and the GLB write port.
// Signals:
//   red_valid     - reducer presents an opsum vector
//   red_ready     - controller accepts the reducer vector
//   store_opsum_f - buffer store strobe (red_valid & red_ready)
//   valid_op      - buffer word valid toward the GLB
//   ready_op      - GLB accepts the word
//   word_idx      - buffer word select
//   glb_addr      - GLB byte address of the current word
// Modports: master = controller side, slave = reducer/buffer/GLB side.
interface opsum_drain_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);

    logic              red_valid;
    logic              red_ready;
    logic              store_opsum_f;
    logic              valid_op;
    logic              ready_op;
    logic [5:0]        word_idx;
    logic [ADDR_W-1:0] glb_addr;

    modport master (
        input  red_valid,
        input  ready_op,
        output red_ready,
        output store_opsum_f,
        output valid_op,
        output word_idx,
        output glb_addr
    );

    modport slave (
        output red_valid,
        output ready_op,
        input  red_ready,
        input  store_opsum_f,
        input  valid_op,
        input  word_idx,
        input  glb_addr
    );

endinterface

// File: rtl/opsum_addr_gen.sv
// Word index and GLB address generator for the opsum drain.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   load       - restart: word_idx <= 0, addr_ptr <= load_addr
//   load_addr  - base byte address for a new operation
//   advance    - one word accepted by the GLB
//   wrap       - the accepted word is the last of the round; word_idx returns to 0
//   word_idx   - current buffer word select
//   addr_ptr   - current GLB byte address
module opsum_addr_gen
    import opsum_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              advance,
    input  logic              wrap,
    output logic [5:0]        word_idx,
    output logic [ADDR_W-1:0] addr_ptr
);

    logic [5:0]        word_idx_q;
    logic [ADDR_W-1:0] addr_ptr_q;

    // addr_ptr is never cleared on wrap, so successive rounds land back to back in the GLB;
    // overflow simply wraps modulo 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx_q <= '0;
            addr_ptr_q <= '0;
        end else if (load) begin
            word_idx_q <= '0;
            addr_ptr_q <= load_addr;
        end else if (advance) begin
            word_idx_q <= wrap ? 6'd0 : word_idx_q + 6'd1;
            addr_ptr_q <= addr_ptr_q + ADDR_W'(GLB_WORD_BYTES);
        end
    end

    assign word_idx = word_idx_q;
    assign addr_ptr = addr_ptr_q;

endmodule

// File: rtl/opsum_drain_ctrl.sv
// Pointwise opsum buffer sequencer. Accepts OPSUM_DEPTH reducer stores per round, then drains
// 2*rows 32-bit words to the GLB one per handshake, repeating for cfg_groups rounds.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   start         - one-cycle pulse; latches config and begins (ignored unless idle)
//   cfg_rows      - active rows 1..32 (0 or >32 means 32)
//   cfg_groups    - number of fill/drain rounds (0 completes immediately)
//   cfg_base_addr - GLB byte address of the first drained word
//   bus           - reducer and GLB handshakes, word select and address (master side)
//   busy          - high whenever not idle
//   done          - one-cycle completion pulse
module opsum_drain_ctrl
    import opsum_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned GRP_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [5:0]         cfg_rows,
    input  logic [GRP_W-1:0]   cfg_groups,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    opsum_drain_ctrl_if.master bus,
    output logic               busy,
    output logic               done
);

    localparam int unsigned FillW = $clog2(OPSUM_DEPTH);

    drain_state_e state_q, state_d;

    logic [5:0]       rows_q;
    logic [GRP_W-1:0] groups_q;
    logic [FillW-1:0] fill_cnt_q;
    logic [GRP_W-1:0] grp_cnt_q;

    logic              red_ready;
    logic              valid_op;
    logic              store;
    logic              handshake;
    logic              start_acc;
    logic              fill_last;
    logic              word_last;
    logic              round_end;
    logic              grp_last;
    logic [6:0]        last_word;
    logic [5:0]        word_idx;
    logic [ADDR_W-1:0] addr_ptr;

    // 2*rows needs 7 bits (64 for a full array); the last index itself fits in 6.
    assign last_word = 7'(rows_q) * 7'(WORDS_PER_ROW) - 7'd1;

    assign start_acc = (state_q == IDLE) && start;
    assign store     = bus.red_valid && red_ready;
    assign handshake = valid_op && bus.ready_op;
    assign fill_last = store && (fill_cnt_q == FillW'(OPSUM_DEPTH - 1));
    assign word_last = ({1'b0, word_idx} == last_word);
    assign round_end = handshake && word_last;
    assign grp_last  = (grp_cnt_q == groups_q - GRP_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (cfg_groups == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (fill_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (round_end) begin
                    state_d = grp_last ? DONE : FILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        red_ready = 1'b0;
        valid_op  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            IDLE:    busy      = 1'b0;
            FILL:    red_ready = 1'b1;
            DRAIN:   valid_op  = 1'b1;
            DONE:    done      = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // Latched configuration plus fill and round counters
    always_ff @(posedge clk) begin
        if (reset) begin
            rows_q     <= '0;
            groups_q   <= '0;
            fill_cnt_q <= '0;
            grp_cnt_q  <= '0;
        end else begin
            if (start_acc) begin
                rows_q     <= clamp_rows(cfg_rows);
                groups_q   <= cfg_groups;
                fill_cnt_q <= '0;
                grp_cnt_q  <= '0;
            end
            if (store) begin
                fill_cnt_q <= fill_last ? '0 : fill_cnt_q + FillW'(1);
            end
            if (round_end) begin
                grp_cnt_q <= grp_cnt_q + GRP_W'(1);
            end
        end
    end

    opsum_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (start_acc),
        .load_addr (cfg_base_addr),
        .advance   (handshake),
        .wrap      (word_last),
        .word_idx  (word_idx),
        .addr_ptr  (addr_ptr)
    );

    assign bus.red_ready     = red_ready;
    assign bus.store_opsum_f = store;
    assign bus.valid_op      = valid_op;
    assign bus.word_idx      = word_idx;
    assign bus.glb_addr      = addr_ptr;

endmodule

// File: tb/tb_opsum_drain_ctrl.sv
// Self-checking bench for opsum_drain_ctrl: vector table, randomized runs against a
// counter-based reference model, and hand-written reset/abort sequences.
module tb_opsum_drain_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  cfg_rows;
    logic [15:0] cfg_groups;
    logic [31:0] cfg_base_addr;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    opsum_drain_ctrl_if #(.ADDR_W(32)) bus ();

    opsum_drain_ctrl #(
        .ADDR_W (32),
        .GRP_W  (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_rows      (cfg_rows),
        .cfg_groups    (cfg_groups),
        .cfg_base_addr (cfg_base_addr),
        .bus           (bus.master),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  rows;
        logic [15:0] groups;
        logic [31:0] base;
        int          rv_pct;
        int          ro_pct;
        int          stall_word;
        bit          restart;
        int          exp_stores;
        int          exp_words;
        logic [31:0] exp_last;
        int          exp_span;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_red_ready"}, bus.red_ready, 0);
        chk({tag, "_store"}, bus.store_opsum_f, 0);
        chk({tag, "_valid_op"}, bus.valid_op, 0);
        chk({tag, "_word_idx"}, bus.word_idx, 0);
        chk({tag, "_glb_addr"}, bus.glb_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Reference model: each round is OPSUM_DEPTH accepted stores followed by 2*rows accepted
    // words; word w of round g goes to base + 4*(g*2*rows + w). Expected outputs each cycle
    // follow purely from those counts.
    task automatic run_case(input vec_t v, output int n_stores, output int n_words,
                            output logic [31:0] last_addr, output int n_done, output int span);
        int eff_rows, wpr, g, st, wd, stall, first_store;
        bit done_due, finished, in_fill;
        eff_rows = (v.rows == 6'd0 || v.rows > 6'd32) ? 32 : int'(v.rows);
        wpr = 2 * eff_rows;
        g = 0; st = 0; wd = 0; stall = 0; first_store = -1;
        done_due = (v.groups == 16'd0);
        finished = 0;
        n_stores = 0; n_words = 0; last_addr = '0; n_done = 0; span = -1;
        bus.red_valid = 1'b0;
        bus.ready_op  = 1'b0;
        cfg_rows = v.rows; cfg_groups = v.groups; cfg_base_addr = v.base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
            if (v.restart && cyc == 1) begin
                start = 1'b1;
                cfg_rows = 6'd1; cfg_groups = 16'd7; cfg_base_addr = 32'hDEAD_0000;
            end else begin
                start = 1'b0;
            end
            bus.red_valid = ($urandom_range(99) < v.rv_pct);
            if (v.stall_word >= 0 && st >= 4 && wd == v.stall_word && g == 0 && stall < 5) begin
                bus.ready_op = 1'b0;
                stall++;
            end else begin
                bus.ready_op = ($urandom_range(99) < v.ro_pct);
            end
            @(negedge clk);
            if (bus.store_opsum_f) begin
                n_stores++;
                if (first_store < 0) first_store = cyc;
            end
            if (bus.valid_op && bus.ready_op) begin
                n_words++;
                last_addr = bus.glb_addr;
            end
            if (done) begin
                n_done++;
                span = cyc - first_store;
            end
            if (done_due) begin
                chk("done_pulse", done, 1);
                chk("busy_in_done", busy, 1);
                chk("ready_in_done", bus.red_ready, 0);
                chk("valid_in_done", bus.valid_op, 0);
                finished = 1;
            end else begin
                in_fill = (st < 4);
                chk("red_ready", bus.red_ready, in_fill);
                chk("valid_op", bus.valid_op, !in_fill);
                chk("store_strobe", bus.store_opsum_f, in_fill && bus.red_valid);
                chk("busy_run", busy, 1);
                chk("done_early", done, 0);
                if (!in_fill) begin
                    chk("word_idx", bus.word_idx, wd);
                    chk("glb_addr", bus.glb_addr, v.base + 32'(4 * (g * wpr + wd)));
                end
                if (in_fill) begin
                    if (bus.red_valid) st++;
                end else if (bus.ready_op) begin
                    wd++;
                    if (wd == wpr) begin
                        wd = 0; st = 0; g++;
                        if (g == int'(v.groups)) done_due = 1;
                    end
                end
            end
            @(posedge clk); #1;
        end
        if (!finished) chk("cycle_budget", 0, 1);
        start = 1'b0;
        bus.red_valid = 1'b0;
        bus.ready_op  = 1'b0;
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_width", done, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        int ns, nw, nd, sp;
        logic [31:0] la;
        run_case(v, ns, nw, la, nd, sp);
        chk({tag, "_stores"}, ns, v.exp_stores);
        chk({tag, "_words"}, nw, v.exp_words);
        chk({tag, "_last_addr"}, la, v.exp_last);
        chk({tag, "_done_count"}, nd, 1);
        if (v.exp_span > 0) chk({tag, "_span"}, sp, v.exp_span);
    endtask

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t rv;
        int dones, eff;
        //         rows   groups  base           rv   ro   stall rst  st  wd   last           span
        vecs[0] = '{6'd2,  16'd1, 32'h0000_0100, 100, 100, -1,   0,   4,  4,   32'h0000_010C, 8};
        vecs[1] = '{6'd32, 16'd2, 32'h0000_1000, 100, 100, -1,   0,   8,  128, 32'h0000_11FC, 136};
        vecs[2] = '{6'd4,  16'd1, 32'h0000_2000, 100, 100, 3,    0,   4,  8,   32'h0000_201C, 17};
        vecs[3] = '{6'd0,  16'd1, 32'h0000_0200, 100, 100, -1,   0,   4,  64,  32'h0000_02FC, 68};
        vecs[4] = '{6'd1,  16'd2, 32'h0000_0040, 100, 100, -1,   0,   8,  4,   32'h0000_004C, 12};
        vecs[5] = '{6'd4,  16'd1, 32'hFFFF_FFF0, 100, 100, -1,   0,   4,  8,   32'h0000_000C, 12};
        vecs[6] = '{6'd40, 16'd1, 32'h0000_0000, 60,  70,  -1,   1,   4,  64,  32'h0000_00FC, 0};
        vecs[7] = '{6'd3,  16'd0, 32'h0000_0300, 100, 100, -1,   0,   0,  0,   32'h0000_0000, 0};
        vecs[8] = '{6'd2,  16'd3, 32'h0000_0500, 50,  50,  -1,   1,   12, 12,  32'h0000_052C, 0};

        reset = 1'b1;
        start = 1'b0;
        cfg_rows = '0; cfg_groups = '0; cfg_base_addr = '0;
        bus.red_valid = 1'b0;
        bus.ready_op  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        for (int i = 0; i < 5; i++) begin
            rv.rows = 6'($urandom_range(40));
            rv.groups = 16'($urandom_range(3, 1));
            rv.base = $urandom;
            rv.rv_pct = $urandom_range(100, 25);
            rv.ro_pct = $urandom_range(100, 25);
            rv.stall_word = -1;
            rv.restart = 1'($urandom_range(1));
            eff = (rv.rows == 6'd0 || rv.rows > 6'd32) ? 32 : int'(rv.rows);
            rv.exp_stores = 4 * int'(rv.groups);
            rv.exp_words = 2 * eff * int'(rv.groups);
            rv.exp_last = rv.base + 32'(4 * (rv.exp_words - 1));
            rv.exp_span = 0;
            check_vec($sformatf("rand%0d", i), rv);
        end

        // Abort mid-drain at word 5: everything clears on the next edge and done never fires.
        cfg_rows = 6'd4; cfg_groups = 16'd1; cfg_base_addr = 32'h0000_3000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.red_valid = 1'b1;
        bus.ready_op  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40 && !(bus.valid_op && bus.word_idx == 6'd5); i++) begin
            @(negedge clk);
        end
        chk("abort_at_w5_idx", bus.word_idx, 5);
        chk("abort_at_w5_addr", bus.glb_addr, 32'h0000_3014);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_idle_outputs("abort");
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy || bus.store_opsum_f) dones++;
        end
        chk("abort_quiet", dones, 0);
        bus.red_valid = 1'b0;
        bus.ready_op  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
